// File: rtl/cfg_loader.sv
// cfg_loader -- serial configuration loader for the 3x3 fabric.
//
// Hunts a serial bitstream for an 8-bit sync word, shifts in a CFG_W-bit
// configuration frame, optionally checks a trailing even-parity bit, then
// commits the frame in a single cycle onto the parallel configuration bus
// that feeds the `roof` inputs of the I/O boxes (box k takes bits 5k+4:5k).
//
// Optional feature: define CFG_LOADER_PARITY_EN to expect a trailing
// even-parity bit after the payload and to let `err` assert. Without it,
// LOAD goes straight to COMMIT and `err` is tied low.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-low reset
//   start      in   1      single-cycle request to arm / re-arm loading
//   bit_in     in   1      serial bitstream data
//   bit_valid  in   1      bit_in is valid this cycle
//   bit_ready  out  1      loader accepts a bit this cycle (state decode)
//   cfg_out    out  CFG_W  committed configuration (registered)
//   cfg_load   out  1      one-cycle pulse, cfg_out was just updated
//   busy       out  1      high in SYNC, LOAD, CHECK and COMMIT (state decode)
//   done       out  1      sticky, last frame committed
//   err        out  1      sticky, last frame failed parity
module cfg_loader #(
  parameter int         CFG_W     = 20,
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_load,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int             CW       = $clog2(CFG_W + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(CFG_W - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SYNC   = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] COMMIT = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
`ifdef CFG_LOADER_PARITY_EN
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] ERROR  = 3'd6;
`endif

  logic [2:0]       state_q,  state_d;
  logic [7:0]       window_q, window_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [CFG_W-1:0] cfg_q,    cfg_d;
  logic             load_q,   load_d;
  logic             done_q,   done_d;
`ifdef CFG_LOADER_PARITY_EN
  logic             err_q,    err_d;
  logic             par_q,    par_d;
`endif

  logic       accept;
  logic [7:0] window_shift;

  assign window_shift = {window_q[6:0], bit_in};

`ifdef CFG_LOADER_PARITY_EN
  assign bit_ready = (state_q == SYNC) || (state_q == LOAD) || (state_q == CHECK);
`else
  assign bit_ready = (state_q == SYNC) || (state_q == LOAD);
`endif
  assign busy   = bit_ready || (state_q == COMMIT);
  assign accept = bit_valid && bit_ready;

  // Next-state logic. IDLE, DONE and ERROR share the default arm: they only
  // react to start, which re-arms the hunt with a cleared window. start is
  // not examined in any busy state, so it is ignored there.
  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    cfg_d    = cfg_q;
    load_d   = 1'b0;
    done_d   = done_q;
`ifdef CFG_LOADER_PARITY_EN
    err_d    = err_q;
    par_d    = par_q;
`endif
    case (state_q)
      SYNC: begin
        if (accept) begin
          window_d = window_shift;
          // Match on the updated window so the next accepted bit is payload.
          if (window_shift == SYNC_WORD) begin
            state_d = LOAD;
            count_d = '0;
`ifdef CFG_LOADER_PARITY_EN
            par_d   = 1'b0;
`endif
          end
        end
      end
      LOAD: begin
        if (accept) begin
          shadow_d = {shadow_q[CFG_W-2:0], bit_in};
          count_d  = count_q + CW'(1);
`ifdef CFG_LOADER_PARITY_EN
          par_d    = par_q ^ bit_in;
          if (count_q == LAST_BIT) state_d = CHECK;
`else
          if (count_q == LAST_BIT) state_d = COMMIT;
`endif
        end
      end
`ifdef CFG_LOADER_PARITY_EN
      CHECK: begin
        if (accept) begin
          // Even parity: payload XOR parity bit must be zero.
          if (par_q ^ bit_in) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            state_d = COMMIT;
          end
        end
      end
`endif
      COMMIT: begin
        cfg_d   = shadow_q;
        load_d  = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: begin
        if (start) begin
          done_d   = 1'b0;
`ifdef CFG_LOADER_PARITY_EN
          err_d    = 1'b0;
`endif
          window_d = '0;
          state_d  = SYNC;
        end
      end
    endcase
  end

  // State registers; reset abandons any frame in flight and clears cfg_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      window_q <= '0;
      shadow_q <= '0;
      count_q  <= '0;
      cfg_q    <= '0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef CFG_LOADER_PARITY_EN
      err_q    <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      cfg_q    <= cfg_d;
      load_q   <= load_d;
      done_q   <= done_d;
`ifdef CFG_LOADER_PARITY_EN
      err_q    <= err_d;
      par_q    <= par_d;
`endif
    end
  end

  assign cfg_out  = cfg_q;
  assign cfg_load = load_q;
  assign done     = done_q;
`ifdef CFG_LOADER_PARITY_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: doc/cfg_loader.md
# cfg_loader

Serial configuration loader for the 3x3 fabric. It hunts a serial bitstream for a sync word, then shifts in a fixed-length configuration frame and optionally checks its parity. On success it commits the frame in one cycle to the parallel configuration bus that drives the `roof` inputs of the I/O boxes; each I/O box takes a 5-bit slice. It sits directly upstream of the I/O boxes and feeds the SRAM config bits they latch.

## Interface
- `CFG_W`, default 20: frame payload width in bits (4 I/O boxes × 5 bits).
- `SYNC_WORD`, default 8'hA5: 8-bit frame marker.
- Clock `clk` and reset `reset`: one clock; `reset` is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request to arm or re-arm loading.
- `bit_in`  in  1  serial bitstream data.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_ready`  out  1  loader accepts a bit this cycle.
- `cfg_out`  out  CFG_W  committed configuration. Bits [5k+4:5k] go to the `roof` input of I/O box k.
- `cfg_load`  out  1  one-cycle pulse; `cfg_out` was just updated.
- `busy`  out  1  high in SYNC, LOAD, CHECK and COMMIT.
- `done`  out  1  sticky; last frame committed.
- `err`  out  1  sticky; last frame failed parity.

## Operation
- A bit transfers on a rising edge when `bit_valid` && `bit_ready`.
- `bit_ready` is decoded from the state only. It is high in SYNC, LOAD and CHECK and low elsewhere.
- The bit counter is ceil(log2(CFG_W+1)) bits wide. The sync window is an 8-bit shift register, new bit in at the LSB.
- **IDLE:** on `start`, clear `done` and `err`, zero the window, go to SYNC.
- **SYNC:**
  - Each accepted bit shifts into the window.
  - If the updated window equals `SYNC_WORD`, go to LOAD with count=0. The sync bits are not part of the payload.
  - Hunting continues with no timeout.
- **LOAD:**
  - Each accepted bit shifts into the shadow register at the LSB, so the first payload bit ends up in `cfg_out[CFG_W-1]`.
  - After the CFG_W-th accepted bit, go to CHECK if parity is compiled in, otherwise go to COMMIT.
- **CHECK:**
  - Accept exactly one parity bit. Even parity: the XOR of the payload and the parity bit must be 0.
  - Pass: go to COMMIT. Fail: set `err`, go to ERROR. The shadow register is discarded and `cfg_out` is unchanged.
- **COMMIT:** `cfg_out` ← shadow, `cfg_load` ← 1 for one cycle, `done` ← 1, go to DONE.
- **DONE / ERROR:** idle with `bit_ready` low. On `start`, clear `done` and `err`, zero the window, go to SYNC. `cfg_out` is held until the next COMMIT.
- `start` is ignored in SYNC, LOAD, CHECK and COMMIT.
- `bit_valid` gaps stall the transfer with no effect on state or count.
- Bits offered while `bit_ready` is low are not consumed.

## Timing
- Reset values:
  - state IDLE
  - `cfg_out`=0, so every I/O box tristates its outputs
  - `cfg_load`=0, `busy`=0, `done`=0, `err`=0
  - window, shadow and count all 0
- A reset mid-frame abandons the frame immediately and clears `cfg_out`.
- `start` at edge N puts the block in SYNC after edge N. `bit_ready` is high from that cycle.
- Final payload or parity bit accepted at edge M:
  - COMMIT state during cycle M..M+1.
  - Edge M+1: `cfg_out` updated, `cfg_load`=1 and `done`=1 during cycle M+1..M+2.
  - `cfg_load` falls after edge M+2.
- Minimum frame: 8 sync bits + CFG_W bits, +1 parity bit when enabled, with one bit accepted per cycle.
- A sync match on the final window bit makes the very next accepted bit payload bit 0. There is no dead cycle.
- All outputs are registered except `bit_ready` and `busy`, which are state decodes.

## Configuration
- `CFG_LOADER_PARITY_EN` defined:
  - CHECK state exists.
  - The frame carries a trailing even-parity bit.
  - `err` can assert.
- Not defined:
  - LOAD goes directly to COMMIT.
  - No parity bit is expected.
  - `err` is tied to 0.

## Test plan
1. **Basic load, parity off:** reset, `start`, stream 8'hA5 then 20'hABCDE with `bit_valid` held high. Expect `cfg_out`=20'hABCDE and a single `cfg_load` pulse one cycle after the last bit, `done`=1, `busy`=0.
2. **Noise before sync:** stream 8'h3C, then 1,0,1, then 8'hA5 and 20'h00001. Expect no load until the true sync word, `cfg_out`=20'h00001, and exactly 20 payload bits consumed.
3. **Parity, `CFG_LOADER_PARITY_EN` defined:**
   - Frame 20'h00003 with parity bit 0: commit, `done`=1.
   - Re-`start` with frame 20'h00007 and parity bit 0: `err`=1, `done`=0, `cfg_out` stays 20'h00003, no `cfg_load`.
4. **Stalls:** random `bit_valid` gaps of 0–5 cycles during sync and payload of 20'h5A5A5. Expect a result identical to the ungapped run. `start` pulsed mid-LOAD has no effect.
5. **Reset mid-frame:** assert `reset` after 10 payload bits. Expect `cfg_out`=0, state IDLE, `bit_ready`=0 asynchronously. A subsequent full frame 20'hFFFFF loads correctly.
6. **Reload:** from DONE holding 20'h12345, `start`, then load 20'h54321. Expect `done` to clear on `start`, then `cfg_out`=20'h54321 with one `cfg_load` pulse.
